// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with power-on clear.
// Holds the storage geometry and the clear-controller state encoding.
package regfile_pkg;

  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_DATA_W   = 32;
  localparam int REGFILE_NUM_REGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer for the register file.
// After reset it walks addresses 1..31, requesting a zero write on each
// edge, then parks in RUN until the next reset.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   busy       out  1 while the clear sequence is running (registered)
//   clear_addr out  address to be zeroed on the current edge (registered)
//   clear_we   out  zero-write request for clear_addr
import regfile_pkg::*;

module regfile_clear_ctrl (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      busy,
  output logic [REGFILE_ADDR_W-1:0] clear_addr,
  output logic                      clear_we
);

  regfile_state_e            state;
  logic [REGFILE_ADDR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= REGFILE_ADDR_W'(1);
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          // The edge that zeroes the top register also ends the sequence.
          if (cnt == REGFILE_ADDR_W'(REGFILE_NUM_REGS - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign clear_addr = cnt;
  assign clear_we   = (state == CLEAR);

endmodule : regfile_clear_ctrl

// File: rtl/regfile_init.sv
// 32 x 32 register file with two combinational read ports, one write port
// and an automatic zero-fill of registers 1..31 after every reset.
// Register 0 is hard-wired to read 0 and is never written.
// Optional feature: define REGFILE_BYPASS_EN to forward WriteData to a read
// port whose address matches a pending write (before the write edge).
// Ports:
//   Clk            in   clock, rising edge
//   Rst_n          in   synchronous active-low reset
//   RegWrite       in   write enable
//   WriteRegister  in   write address (5 bits)
//   WriteData      in   write data (32 bits)
//   ReadRegister1  in   read address, port 1
//   ReadRegister2  in   read address, port 2
//   ReadData1      out  read data, port 1 (0 while Busy)
//   ReadData2      out  read data, port 2 (0 while Busy)
//   Busy           out  1 during reset and while the clear sequence runs
import regfile_pkg::*;

module regfile_init (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      RegWrite,
  input  logic [REGFILE_ADDR_W-1:0] WriteRegister,
  input  logic [REGFILE_DATA_W-1:0] WriteData,
  input  logic [REGFILE_ADDR_W-1:0] ReadRegister1,
  input  logic [REGFILE_ADDR_W-1:0] ReadRegister2,
  output logic [REGFILE_DATA_W-1:0] ReadData1,
  output logic [REGFILE_DATA_W-1:0] ReadData2,
  output logic                      Busy
);

  logic                      busy_q;
  logic [REGFILE_ADDR_W-1:0] clear_addr;
  logic                      clear_we;
  logic                      blank;
  logic                      wr_en;

  logic [REGFILE_DATA_W-1:0] mem [REGFILE_NUM_REGS];

  regfile_clear_ctrl u_clear_ctrl (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .busy       (busy_q),
    .clear_addr (clear_addr),
    .clear_we   (clear_we)
  );

  // Reset is folded in so Busy and the blanked reads hold from the very
  // first cycle of reset, before the controller has seen an edge.
  assign blank = busy_q | ~Rst_n;
  assign Busy  = blank;

  // Host writes are only honoured in RUN; requests during clear are dropped.
  assign wr_en = RegWrite && (WriteRegister != '0) && !busy_q;

  // Storage has no reset of its own; the clear sequence zeroes it instead.
  // A reset edge suppresses both clear and host writes.
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      if (clear_we) begin
        mem[clear_addr] <= '0;
      end else if (wr_en) begin
        mem[WriteRegister] <= WriteData;
      end
    end
  end

  always_comb begin
    ReadData1 = '0;
    if (!blank && (ReadRegister1 != '0)) begin
      ReadData1 = mem[ReadRegister1];
    end
`ifdef REGFILE_BYPASS_EN
    if (!blank && wr_en && (WriteRegister == ReadRegister1)) begin
      ReadData1 = WriteData;
    end
`endif
  end

  always_comb begin
    ReadData2 = '0;
    if (!blank && (ReadRegister2 != '0)) begin
      ReadData2 = mem[ReadRegister2];
    end
`ifdef REGFILE_BYPASS_EN
    if (!blank && wr_en && (WriteRegister == ReadRegister2)) begin
      ReadData2 = WriteData;
    end
`endif
  end

endmodule : regfile_init

// File: tb/tb_regfile_init.sv
// Testbench for regfile_init: reference model plus queued scoreboard.
module tb_regfile_init;

  logic        Clk;
  logic        Rst_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy;

  regfile_init dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .Busy          (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [31:0] m_mem [32];
  bit          m_busy = 1'b1;
  int          m_cnt  = 1;

  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (!Rst_n) begin
      m_busy = 1'b1;
      m_cnt  = 1;
    end else if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 31) m_busy = 1'b0;
      m_cnt++;
    end else if (RegWrite && WriteRegister != 0) begin
      m_mem[WriteRegister] = WriteData;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] ra);
    logic [31:0] v;
    if (!Rst_n || m_busy) return 32'h0;
    if (ra == 0) return 32'h0;
    v = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteRegister != 0 && WriteRegister == ra) v = WriteData;
`endif
    return v;
  endfunction

  // Drive both read addresses, queue the model's answer, then score the DUT.
  task automatic expect_read(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    exp_q.push_back(model_read(a1));
    exp_q.push_back(model_read(a2));
    #1;
    check({tag, "_rd1"}, ReadData1, exp_q.pop_front());
    check({tag, "_rd2"}, ReadData2, exp_q.pop_front());
  endtask

  task automatic expect_busy(input string tag);
    check(tag, {31'b0, Busy}, {31'b0, (m_busy || !Rst_n)});
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    tick();
    RegWrite      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    Rst_n = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd31;

    // Reset held for two edges.
    tick();
    tick();
    expect_busy("reset_busy");
    expect_read("reset_rd", 5'd5, 5'd31);

    // Release and measure the clear duration.
    Rst_n = 1'b1;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      expect_busy("clear_busy");
      tick();
      n++;
    end
    check("busy_len", n, 31);
    expect_busy("run_busy");
    expect_read("clr_5_31", 5'd5, 5'd31);

    // Basic writes, both ports on the written register.
    do_write(5'd2, 32'd42);
    expect_read("w42", 5'd2, 5'd2);
    do_write(5'd2, 32'd15);
    expect_read("w15", 5'd2, 5'd2);

    // Disabled write must not modify storage.
    RegWrite = 1'b0; WriteRegister = 5'd2; WriteData = 32'd16;
    tick();
    expect_read("nowe", 5'd2, 5'd2);

    // Register 0 and address isolation.
    do_write(5'd0, 32'd18);
    expect_read("r0", 5'd0, 5'd0);
    do_write(5'd3, 32'd17);
    expect_read("iso", 5'd3, 5'd2);

    // Fill a spread of registers, then sweep every address pair.
    for (int i = 1; i < 32; i += 3) do_write(5'(i), $urandom());
    for (int i = 0; i < 32; i++) begin
      expect_read("sweep", 5'(i), 5'(31 - i));
      tick();
    end

    // Reset from RUN, write during clear, then reset again mid-clear.
    ReadRegister1 = 5'd2; ReadRegister2 = 5'd4;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'd99;
      end else begin
        RegWrite = 1'b0;
      end
      expect_read("clear_blank", 5'd2, 5'd4);
      expect_busy("clear_busy2");
      tick();
    end
    RegWrite = 1'b0;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("busy_len_restart", n, 31);
    expect_read("dropped_w4", 5'd4, 5'd2);
    for (int i = 0; i < 32; i++) begin
      expect_read("zero_sweep", 5'(i), 5'(i));
      tick();
    end

    // Forwarding behaviour before the write edge.
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hDEADBEEF;
    expect_read("bypass_pre", 5'd7, 5'd6);
    tick();
    RegWrite = 1'b0;
    expect_read("bypass_post", 5'd7, 5'd7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_regfile_init

// File: doc/regfile_init.md
REGFILE_INIT -- requirements
Module: regfile_init

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be named Clk and Rst_n.
- REQ-002: Clk  input  1  clock; all state updates occur on the rising edge.
- REQ-003: Rst_n  input  1  reset, synchronous, active-low.
- REQ-004: RegWrite  input  1  write enable, sampled at the Clk rising edge.
- REQ-005: WriteRegister  input  5  write address.
- REQ-006: WriteData  input  32  write data.
- REQ-007: ReadRegister1 and ReadRegister2  input  5 each  read addresses for ports 1 and 2.
- REQ-008: ReadData1 and ReadData2  output  32 each  read data, combinational from the address inputs and the stored state.
- REQ-009: Busy  output  1  high while the clear sequence runs.

Function
- REQ-010: Storage SHALL be 32 registers of 32 bits, and address 0 SHALL always read 0.
- REQ-011: The FSM SHALL have two states, CLEAR and RUN.
  - CLEAR -> RUN on the edge that clears register 31.
  - RUN persists until Rst_n is low.
- REQ-012: In CLEAR, a 5-bit counter SHALL start at 1; each edge writes 0 to mem[counter] and increments the counter.
  - The clear sequence takes exactly 31 cycles.
  - Register 0 is skipped.
- REQ-013: Busy SHALL equal 1 in CLEAR and 0 in RUN.
- REQ-014: In RUN, an edge with RegWrite=1 and WriteRegister!=0 SHALL store WriteData in mem[WriteRegister].
  - The new value is visible on ReadData in the same cycle following that edge (zero read latency after the write edge).
- REQ-015: Writes with RegWrite=0, or with WriteRegister=0, SHALL leave all storage unchanged.
- REQ-016: Writes requested during CLEAR SHALL be dropped silently; they are not queued.
- REQ-017: ReadData1 and ReadData2 SHALL be 0 while Busy=1, regardless of address.
- REQ-018: Both read ports SHALL be independent.
  - Both ports SHALL be allowed to address the same register.
  - Both ports SHALL be allowed to address the register being written.
- REQ-019: After the first completed clear, the outputs SHALL never carry X or Z.

Reset
- REQ-020: Rst_n=0 at an edge SHALL force state=CLEAR, counter=1 and Busy=1, and SHALL cancel any write on that edge.
- REQ-021: Reset asserted mid-CLEAR SHALL restart the sequence at counter=1.
- REQ-022: Reset asserted in RUN SHALL re-enter CLEAR; every register reads 0 once Busy falls.
- REQ-023: Output values during and after reset are as follows.
  - ReadData1 and ReadData2 are 0 during reset and during CLEAR.
  - Busy is 1 during reset.

Configuration
- REQ-024: Macro REGFILE_BYPASS_EN selects write-to-read forwarding.
  - Defined: in RUN, when RegWrite=1, WriteRegister!=0 and WriteRegister equals ReadRegisterN, ReadDataN SHALL equal WriteData combinationally, before the edge.
  - Not defined: ReadDataN SHALL show the stored value until the write edge.
- REQ-025: The macro SHALL NOT alter clear, reset or register-0 behaviour.

Structure
- REQ-026: Shared package regfile_pkg SHALL hold the following:
  - REGFILE_ADDR_W=5
  - REGFILE_DATA_W=32
  - REGFILE_NUM_REGS=32
  - the state enum {CLEAR, RUN}.
- REQ-027: The clear FSM and counter SHALL be the sub-module regfile_clear_ctrl.
  - Outputs: Busy, clear address, clear write enable.
  - The storage array and read muxing stay in regfile_init.

Verification
- REQ-028: Hold Rst_n=0 for 2 cycles, then release.
  - Busy SHALL be 1 for exactly 31 cycles, then 0.
  - Registers 5 and 31 SHALL read 0 with no X.
- REQ-029: After Busy=0, write 42 to register 2 (RegWrite=1) for one edge.
  - Both ports at address 2 SHALL read 42.
  - Then write 15: both ports SHALL read 15.
- REQ-030: Drive RegWrite=0, WriteData=16, WriteRegister=2 for one edge: register 2 SHALL still read 15.
- REQ-031: Register-0 and address-isolation check.
  - Write 18 to register 0: it SHALL read 0.
  - Then write 17 to register 3: register 3 SHALL read 17 and register 2 SHALL stay 15.
- REQ-032: Write 99 to register 4 in cycle 5 of CLEAR.
  - Register 4 SHALL read 0 after Busy falls.
  - Asserting Rst_n=0 in cycle 10 SHALL extend Busy to 31 cycles counted from the reset release.
- REQ-033: In RUN, set RegWrite=1, WriteRegister=7, WriteData=0xDEADBEEF, ReadRegister1=7, and sample before the edge.
  - With REGFILE_BYPASS_EN, ReadData1 SHALL be 0xDEADBEEF.
  - Without it, ReadData1 SHALL be 0 until the edge and 0xDEADBEEF after it.
